reflet_int_to_float: RTL

- Sequential signed-integer to floating-point converter.
- Sits directly upstream of the float multiplier; its out port feeds a multiplier operand.
- Normalises by shifting one bit per cycle, which avoids a wide combinational priority encoder and barrel shifter.
- Float layout and sizes come from the shared float-function header (mantissa_size, exponent_size, exponent_bias of float_size).

---
 rtl/reflet_int_to_float.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/reflet_int_to_float.sv
// reflet_int_to_float: sequential signed-integer to float converter.
// Normalises the magnitude one bit per cycle to avoid a wide priority
// encoder and barrel shifter. Default build truncates toward zero.
// Optional macro REFLET_FLOAT_ROUND_EN adds a ROUND state that applies
// round-to-nearest-even (guard + sticky) before the result is written.
module reflet_int_to_float #(
  parameter int unsigned float_size = 32,
  parameter int unsigned int_size   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [int_size-1:0]   in_int,
  output logic                  ready,
  output logic                  done,
  output logic [float_size-1:0] out
);

  // Float field sizes, matching the shared float-function layout.
  localparam int unsigned MSZ   = (float_size == 64) ? 52 :
                                  (float_size == 16) ? 10 : 23;
  localparam int unsigned ESZ   = float_size - 1 - MSZ;
  localparam int unsigned BIAS  = (1 << (ESZ - 1)) - 1;
  localparam int unsigned CNT_W = $clog2(int_size);
  localparam int unsigned EXT_W = int_size - 1 + MSZ;

`ifdef REFLET_FLOAT_ROUND_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_DONE  = 2'd2,
    S_ROUND = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [int_size-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sign_q, sign_d;
  logic [float_size-1:0] out_q, out_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;

  // Fraction bits below the hidden one, zero-padded on the right.
  logic [EXT_W-1:0]      frac_ext;
  logic [MSZ-1:0]        mnt;
  logic [ESZ-1:0]        biased_exp;
`ifdef REFLET_FLOAT_ROUND_EN
  logic                  guard;
  logic                  sticky;
  logic [ESZ+MSZ-1:0]    rounded;
`endif

  assign ready = ready_q;
  assign done  = done_q;
  assign out   = out_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      out_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Next-state, normalisation datapath and registered output values.
  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    out_d      = out_q;

    frac_ext   = {mag_q[int_size-2:0], {MSZ{1'b0}}};
    mnt        = MSZ'(frac_ext >> (int_size - 1));
    biased_exp = ESZ'(int'(BIAS) + int'(int_size) - 1 - int'(cnt_q));
`ifdef REFLET_FLOAT_ROUND_EN
    guard      = frac_ext[int_size-2];
    sticky     = |frac_ext[int_size-3:0];
    rounded    = {biased_exp, mnt};
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d = in_int[int_size-1];
          mag_d  = in_int[int_size-1] ? (~in_int + int_size'(1)) : in_int;
          cnt_d  = '0;
          if (in_int == '0) begin
            out_d   = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (!mag_q[int_size-1]) begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
`ifdef REFLET_FLOAT_ROUND_EN
          state_d = S_ROUND;
`else
          out_d   = {sign_q, biased_exp, mnt};
          state_d = S_DONE;
`endif
        end
      end
`ifdef REFLET_FLOAT_ROUND_EN
      S_ROUND: begin
        // Carry out of the mantissa ripples into the exponent field.
        if (guard && (sticky || mnt[0])) begin
          rounded = rounded + (ESZ + MSZ)'(1);
        end
        out_d   = {sign_q, rounded};
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
  end

endmodule
